spart: RTL

SPART -- requirements
Module: spart

---
 rtl/spart_pkg.sv | 25 ++
 rtl/spart_baud_gen.sv | 49 ++++
 rtl/spart.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
`timescale 1ns/1ps
// Shared constants and state types for the SPART serial port.
package spart_pkg;

    // Register map
    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBLO = 2'b10;
    localparam logic [1:0] ADDR_DBHI = 2'b11;

    // Bit timing in baud ticks
    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = 8;

    // Tick-counter compare values (counters are 4 bits wide)
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'(HALF_BIT - 1);

    // 9600 baud from 50 MHz at 16x oversampling
    localparam logic [15:0] DIV_DEFAULT = 16'd325;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
`timescale 1ns/1ps
// Baud tick generator: programmable 16-bit divisor and a reloading down-counter.
// tick is high for one cycle every divisor+1 cycles.
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [7:0]  wdata,
    output logic [15:0] divisor,
    output logic        tick
);

    logic [15:0] div_reg, div_next;
    logic [15:0] cnt_reg, cnt_next;

    // Divisor byte updates; a divisor write restarts the count from the new value
    always_comb begin
        div_next = div_reg;
        cnt_next = cnt_reg;
        if (wr_lo) div_next[7:0]  = wdata;
        if (wr_hi) div_next[15:8] = wdata;
        if (wr_lo || wr_hi)
            cnt_next = div_next;
        else if (cnt_reg == 16'd0)
            cnt_next = div_reg;
        else
            cnt_next = cnt_reg - 16'd1;
    end

    // Divisor and counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_reg <= DIV_RESET;
            cnt_reg <= DIV_RESET;
        end else begin
            div_reg <= div_next;
            cnt_reg <= cnt_next;
        end
    end

    assign divisor = div_reg;
    assign tick    = (cnt_reg == 16'd0);

endmodule

// File: rtl/spart.sv
`timescale 1ns/1ps
// SPART: bus-attached UART with 8N1 framing, 16x oversampled receiver,
// independent transmitter and receiver, and a programmable baud divisor.
module spart
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    logic        bus_rd, bus_wr, wr_buf, rd_buf, tick;
    logic [15:0] divisor;
    logic [7:0]  rdata;

    assign bus_rd = iocs & iorw;
    assign bus_wr = iocs & ~iorw;
    assign wr_buf = bus_wr && (ioaddr == ADDR_BUF);
    assign rd_buf = bus_rd && (ioaddr == ADDR_BUF);

    spart_baud_gen #(.DIV_RESET(DIV_RESET)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .wr_lo   (bus_wr && (ioaddr == ADDR_DBLO)),
        .wr_hi   (bus_wr && (ioaddr == ADDR_DBHI)),
        .wdata   (databus),
        .divisor (divisor),
        .tick    (tick)
    );

    // ---------------- transmitter ----------------
    tx_state_t  tx_state_reg, tx_state_next;
    logic [7:0] tx_shift_reg, tx_shift_next;
    logic [3:0] tx_tcnt_reg, tx_tcnt_next;
    logic [2:0] tx_bit_reg, tx_bit_next;
    logic       tx_go_reg, tx_go_next;   // start bit is on the line
    logic       txd_reg, txd_next;

    // TX next-state: wait for the first tick after load, then 10 bits of 16 ticks
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_shift_next = tx_shift_reg;
        tx_tcnt_next  = tx_tcnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_go_next    = tx_go_reg;
        txd_next      = txd_reg;
        case (tx_state_reg)
            TX_IDLE: begin
                txd_next = 1'b1;
                if (wr_buf) begin
                    tx_shift_next = databus;
                    tx_go_next    = 1'b0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: if (tick) begin
                if (!tx_go_reg) begin
                    tx_go_next   = 1'b1;
                    txd_next     = 1'b0;
                    tx_tcnt_next = 4'd0;
                end else if (tx_tcnt_reg == LAST_TICK) begin
                    tx_state_next = TX_DATA;
                    tx_tcnt_next  = 4'd0;
                    tx_bit_next   = 3'd0;
                    txd_next      = tx_shift_reg[0];
                end else begin
                    tx_tcnt_next = tx_tcnt_reg + 4'd1;
                end
            end
            TX_DATA: if (tick) begin
                if (tx_tcnt_reg == LAST_TICK) begin
                    tx_tcnt_next = 4'd0;
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = TX_STOP;
                        txd_next      = 1'b1;
                    end else begin
                        tx_bit_next   = tx_bit_reg + 3'd1;
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        txd_next      = tx_shift_reg[1];
                    end
                end else begin
                    tx_tcnt_next = tx_tcnt_reg + 4'd1;
                end
            end
            TX_STOP: if (tick) begin
                if (tx_tcnt_reg == LAST_TICK) begin
                    tx_state_next = TX_IDLE;
                    tx_tcnt_next  = 4'd0;
                end else begin
                    tx_tcnt_next = tx_tcnt_reg + 4'd1;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // TX state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_reg <= TX_IDLE;
            tx_shift_reg <= 8'h00;
            tx_tcnt_reg  <= 4'd0;
            tx_bit_reg   <= 3'd0;
            tx_go_reg    <= 1'b0;
            txd_reg      <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_shift_reg <= tx_shift_next;
            tx_tcnt_reg  <= tx_tcnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_go_reg    <= tx_go_next;
            txd_reg      <= txd_next;
        end
    end

    assign txd = txd_reg;
    assign tbr = (tx_state_reg == TX_IDLE);

    // ---------------- receiver ----------------
    logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rxd;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    rx_state_t  rx_state_reg, rx_state_next;
    logic [7:0] rx_shift_reg, rx_shift_next;
    logic [3:0] rx_tcnt_reg, rx_tcnt_next;
    logic [2:0] rx_bit_reg, rx_bit_next;
    logic [7:0] rx_buf_reg, rx_buf_next;
    logic       rda_reg, rda_next;
    logic       rx_done;

    // RX next-state: verify start at mid-bit, then sample every 16 ticks
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_shift_next = rx_shift_reg;
        rx_tcnt_next  = rx_tcnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_buf_next   = rx_buf_reg;
        rda_next      = rda_reg;
        rx_done       = 1'b0;
        case (rx_state_reg)
            RX_IDLE: if (rx_prev_reg && !rx_sync_reg) begin
                rx_state_next = RX_START;
                rx_tcnt_next  = 4'd0;
            end
            RX_START: if (tick) begin
                if (rx_tcnt_reg == MID_TICK) begin
                    rx_tcnt_next = 4'd0;
                    rx_bit_next  = 3'd0;
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end else begin
                    rx_tcnt_next = rx_tcnt_reg + 4'd1;
                end
            end
            RX_DATA: if (tick) begin
                if (rx_tcnt_reg == LAST_TICK) begin
                    rx_tcnt_next  = 4'd0;
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
                    else                    rx_bit_next   = rx_bit_reg + 3'd1;
                end else begin
                    rx_tcnt_next = rx_tcnt_reg + 4'd1;
                end
            end
            RX_STOP: if (tick) begin
                if (rx_tcnt_reg == LAST_TICK) begin
                    rx_tcnt_next  = 4'd0;
                    rx_state_next = RX_IDLE;
                    rx_done       = rx_sync_reg;
                end else begin
                    rx_tcnt_next = rx_tcnt_reg + 4'd1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
        // A completing byte wins over a same-cycle buffer read
        if (rx_done) begin
            rx_buf_next = rx_shift_reg;
            rda_next    = 1'b1;
        end else if (rd_buf) begin
            rda_next = 1'b0;
        end
    end

    // RX state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_reg <= RX_IDLE;
            rx_shift_reg <= 8'h00;
            rx_tcnt_reg  <= 4'd0;
            rx_bit_reg   <= 3'd0;
            rx_buf_reg   <= 8'h00;
            rda_reg      <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_shift_reg <= rx_shift_next;
            rx_tcnt_reg  <= rx_tcnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_buf_reg   <= rx_buf_next;
            rda_reg      <= rda_next;
        end
    end

    assign rda = rda_reg;

    // Read-data mux for the selected register
    always_comb begin
        rdata = 8'h00;
        case (ioaddr)
            ADDR_BUF:  rdata = rx_buf_reg;
            ADDR_STAT: rdata = {6'b0, tbr, rda_reg};
            ADDR_DBLO: rdata = divisor[7:0];
            ADDR_DBHI: rdata = divisor[15:8];
            default:   rdata = 8'h00;
        endcase
    end

    assign databus = bus_rd ? rdata : 8'hzz;

endmodule
